serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 123 ++++++++++++
 tb/tb_serial_addsub.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract: processes CHUNK bits per cycle, N/CHUNK cycles per operation.
module serial_addsub #(
  parameter int unsigned N     = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  input  logic         signed_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] final_sum,
  output logic         cout,
  output logic         negative_flag,
  output logic         overflow_flag,
  output logic         zero_flag
);

  localparam int unsigned NSLICE = N / CHUNK;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, b_q, sum_q;
  logic            carry_q, cout_q, sub_q, sgn_q;
  logic [CW-1:0]   k_q;

  logic            accept_c, step_c, last_c;
  logic [CHUNK-1:0] a_sl_c, b_sl_c;
  logic [CHUNK:0]  slice_sum_c;
  logic            done_c, ovf_s_c, ovf_u_c;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    step_c    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    last_c    = (k_q == CW'(NSLICE - 1));
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        step_c = 1'b1;
        if (last_c) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Current slice of the operands and its sum with the running carry.
  always_comb begin
    a_sl_c      = a_q[32'(k_q) * CHUNK +: CHUNK];
    b_sl_c      = b_q[32'(k_q) * CHUNK +: CHUNK];
    slice_sum_c = {1'b0, a_sl_c} + {1'b0, b_sl_c} + (CHUNK + 1)'(carry_q);
  end

  // Operand capture on accept, then one slice per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      sub_q   <= 1'b0;
      sgn_q   <= 1'b0;
      k_q     <= '0;
    end else if (accept_c) begin
      // Subtraction is a + ~b + ~borrow_in.
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? ~cin : cin;
      sub_q   <= sub;
      sgn_q   <= signed_en;
      k_q     <= '0;
    end else if (step_c) begin
      sum_q[32'(k_q) * CHUNK +: CHUNK] <= slice_sum_c[CHUNK-1:0];
      carry_q <= slice_sum_c[CHUNK];
      k_q     <= k_q + CW'(1);
      if (last_c) cout_q <= slice_sum_c[CHUNK];
    end
  end

  // Flags from latched result and mode; only asserted while a result is presented.
  always_comb begin
    done_c        = (state_q == DONE);
    ovf_s_c       = (a_q[N-1] == b_q[N-1]) && (sum_q[N-1] != a_q[N-1]);
    ovf_u_c       = sub_q ? ~cout_q : cout_q;
    zero_flag     = done_c && (sum_q == '0);
    negative_flag = done_c && sgn_q && sum_q[N-1];
    overflow_flag = done_c && (sgn_q ? ovf_s_c : ovf_u_c);
    final_sum     = sum_q;
    cout          = cout_q;
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: 8-bit/4-bit-chunk instance plus default 64/16 instance.
module tb_serial_addsub;

  localparam int K8  = 2;
  localparam int K64 = 4;

  typedef struct {
    logic [63:0] sum;
    logic        c, n, o, z;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ordy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q8[$];
  exp_t q64[$];

  // 8-bit instance signals
  logic        iv8, ir8, cin8, sub8, sgn8, ov8, co8, n8, o8, z8;
  logic [7:0]  a8, b8, fs8;
  // 64-bit instance signals
  logic        iv64, ir64, cin64, sub64, sgn64, ov64, co64, n64, o64, z64;
  logic [63:0] a64, b64, fs64;

  serial_addsub #(.N(8), .CHUNK(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .signed_en(sgn8), .out_valid(ov8), .out_ready(ordy),
    .final_sum(fs8), .cout(co8), .negative_flag(n8), .overflow_flag(o8), .zero_flag(z8)
  );

  serial_addsub u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .cin(cin64), .sub(sub64), .signed_en(sgn64), .out_valid(ov64), .out_ready(ordy),
    .final_sum(fs64), .cout(co64), .negative_flag(n64), .overflow_flag(o64), .zero_flag(z64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Monitor for the 8-bit instance: latency, hold stability, pulse width, payload.
  bit         pov8 = 0, pxf8 = 0;
  logic [7:0] hs8;
  logic       hc8, hn8, ho8, hz8;
  exp_t       e8;
  always @(negedge clk) begin
    if (ov8) begin
      chk("ready_in_done8", 64'(ir8), 64'd0);
      if (pxf8) chk("pulse_after_xfer8", 64'(ov8), 64'd0);
      if (!pov8 && q8.size() != 0) chk("latency8", 64'(cyc - q8[0].acc), 64'(K8));
      if (pov8 && !pxf8) begin
        chk("hold_sum8", 64'(fs8), 64'(hs8));
        chk("hold_flags8", 64'({co8, n8, o8, z8}), 64'({hc8, hn8, ho8, hz8}));
      end
      if (ordy) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result8 got=%h exp=none", fs8);
        end else begin
          e8 = q8.pop_front();
          chk("sum8", 64'(fs8), e8.sum);
          chk("cout8", 64'(co8), 64'(e8.c));
          chk("nflag8", 64'(n8), 64'(e8.n));
          chk("oflag8", 64'(o8), 64'(e8.o));
          chk("zflag8", 64'(z8), 64'(e8.z));
        end
      end
    end
    pov8 = ov8;
    pxf8 = ov8 && ordy;
    hs8 = fs8; hc8 = co8; hn8 = n8; ho8 = o8; hz8 = z8;
  end

  // Monitor for the 64-bit instance.
  bit   pov64 = 0, pxf64 = 0;
  exp_t e64;
  always @(negedge clk) begin
    if (ov64) begin
      if (pxf64) chk("pulse_after_xfer64", 64'(ov64), 64'd0);
      if (!pov64 && q64.size() != 0) chk("latency64", 64'(cyc - q64[0].acc), 64'(K64));
      if (ordy) begin
        if (q64.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result64 got=%h exp=none", fs64);
        end else begin
          e64 = q64.pop_front();
          chk("sum64", fs64, e64.sum);
          chk("cout64", 64'(co64), 64'(e64.c));
          chk("nflag64", 64'(n64), 64'(e64.n));
          chk("oflag64", 64'(o64), 64'(e64.o));
          chk("zflag64", 64'(z64), 64'(e64.z));
        end
      end
    end
    pov64 = ov64;
    pxf64 = ov64 && ordy;
  end

  task automatic wait_idle8();
    int n = 0;
    @(posedge clk); #1;
    while (!ir8 && n < 50) begin @(posedge clk); #1; n++; end
    if (!ir8) chk("idle_timeout8", 64'(ir8), 64'd1);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                        input logic g, input logic [7:0] es, input logic ec, input logic en,
                        input logic eo, input logic ez, input bit push);
    wait_idle8();
    iv8 = 1'b1; a8 = a; b8 = b; cin8 = c; sub8 = s; sgn8 = g;
    @(posedge clk); #1;
    iv8 = 1'b0;
    if (push) q8.push_back('{64'(es), ec, en, eo, ez, cyc});
  endtask

  task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s,
                         input logic g, input logic [63:0] es, input logic ec, input logic en,
                         input logic eo, input logic ez);
    int n = 0;
    @(posedge clk); #1;
    while (!ir64 && n < 50) begin @(posedge clk); #1; n++; end
    if (!ir64) chk("idle_timeout64", 64'(ir64), 64'd1);
    iv64 = 1'b1; a64 = a; b64 = b; cin64 = c; sub64 = s; sgn64 = g;
    @(posedge clk); #1;
    iv64 = 1'b0;
    q64.push_back('{es, ec, en, eo, ez, cyc});
  endtask

  initial begin
    #100000;
    checks++; errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int acc, n;
    iv8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0; sgn8 = 0;
    iv64 = 0; a64 = '0; b64 = '0; cin64 = 0; sub64 = 0; sgn64 = 0;
    ordy = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready8", 64'(ir8), 64'd1);
    chk("rst_valid8", 64'(ov8), 64'd0);
    chk("rst_sum8", 64'(fs8), 64'd0);
    chk("rst_flags8", 64'({co8, n8, o8, z8}), 64'd0);
    chk("rst_ready64", 64'(ir64), 64'd1);
    chk("rst_out64", {fs64[62:0], co64 | n64 | o64 | z64 | ov64}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    //     a      b      cin sub sgn  sum    c  n  o  z
    issue8(8'd5,  8'd3,  0,  0,  0,   8'h08, 0, 0, 0, 0, 1);
    issue8(8'd5,  8'd7,  0,  1,  1,   8'hFE, 0, 1, 0, 0, 1);
    issue8(8'd5,  8'd7,  0,  1,  0,   8'hFE, 0, 0, 1, 0, 1);
    issue8(8'd127, 8'd1, 0,  0,  1,   8'h80, 0, 1, 1, 0, 1);
    issue8(8'd127, 8'd1, 0,  0,  0,   8'h80, 0, 0, 0, 0, 1);
    issue8(8'hFF, 8'h01, 0,  0,  0,   8'h00, 1, 0, 1, 1, 1);
    issue8(8'd5,  8'd3,  1,  0,  0,   8'h09, 0, 0, 0, 0, 1);
    issue8(8'd5,  8'd3,  1,  1,  0,   8'h01, 1, 0, 0, 0, 1);
    issue8(8'h80, 8'h01, 0,  1,  1,   8'h7F, 1, 0, 1, 0, 1);

    // Back-pressure: result held, stray in_valid pulses ignored.
    wait_idle8();
    ordy = 1'b0;
    issue8(8'h12, 8'h34, 0, 0, 0, 8'h46, 0, 0, 0, 0, 1);
    n = 0;
    while (!ov8 && n < 20) begin @(posedge clk); #1; n++; end
    chk("hold_reached_done8", 64'(ov8), 64'd1);
    repeat (5) begin
      iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1; sgn8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_xfer8", 64'({ir8, ov8}), 64'b10);

    // in_valid held high: no accept in the transfer cycle, interval K+2.
    wait_idle8();
    iv8 = 1'b1; a8 = 8'd1; b8 = 8'd1; cin8 = 0; sub8 = 0; sgn8 = 0;
    @(posedge clk); #1;
    acc = cyc;
    q8.push_back('{64'h02, 1'b0, 1'b0, 1'b0, 1'b0, acc});
    q8.push_back('{64'h02, 1'b0, 1'b0, 1'b0, 1'b0, acc + K8 + 2});
    repeat (K8 + 2) @(posedge clk);
    #1 iv8 = 1'b0;

    // Reset in the middle of CALC: nothing delivered, outputs cleared at once.
    issue8(8'h11, 8'h22, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready8", 64'(ir8), 64'd1);
    chk("midrst_valid8", 64'(ov8), 64'd0);
    chk("midrst_sum8", 64'(fs8), 64'd0);
    chk("midrst_flags8", 64'({co8, n8, o8, z8}), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    issue8(8'h0F, 8'h01, 0, 0, 0, 8'h10, 0, 0, 0, 0, 1);

    // Default width instance.
    issue64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 1, 64'h8000_0000_0000_0000, 0, 1, 1, 0);
    issue64(64'd0, 64'd1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 0);

    n = 0;
    while ((q8.size() != 0 || q64.size() != 0 || !ir8 || !ir64) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain8", 64'(q8.size()), 64'd0);
    chk("drain64", 64'(q64.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
